clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_ch.sv | 89 ++++++++
 rtl/clk_div_multi.sv | 50 +++++
 tb/tb_clk_div_multi.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and per-channel state record for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DIV_MIN  = 2;
  localparam int N_CH_MAX = 16;

  typedef struct packed {
    logic pend;
    logic run;
    logic ph;
    logic tick;
  } ch_state_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: active/shadow divisor, period counter and registered phase/tick.
// Optional CLKDIV_SYNC_EN adds a sync input that restarts the phase like an enable rise.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int W       = 31,
  parameter int DEF_DIV = 50000000
) (
  input  logic         clki,
  input  logic         rst_n,
  input  logic         en,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
`ifdef CLKDIV_SYNC_EN
  input  logic         sync,
`endif
  output logic         clko,
  output logic         tick,
  output logic         pend
);

  localparam logic [W-1:0] DEF_D = W'(DEF_DIV);
  localparam logic [W-1:0] MIN_D = W'(DIV_MIN);
  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W:0]   ONE_X = (W+1)'(1);

  logic [W-1:0] d_reg, d_next;
  logic [W-1:0] s_reg, s_next;
  logic [W-1:0] cnt_reg, cnt_next;
  ch_state_t    st_reg, st_next;
  logic         restart;
  logic         wrap;
  logic [W:0]   half;

  always_comb begin
    d_next   = d_reg;
    s_next   = s_reg;
    cnt_next = cnt_reg;
    st_next  = st_reg;
    half     = '0;
    restart  = !st_reg.run;
`ifdef CLKDIV_SYNC_EN
    restart  = restart | sync;
`endif
    wrap     = (cnt_reg == d_reg - ONE);

    if (!en) begin
      cnt_next     = '0;
      st_next.run  = 1'b0;
      st_next.ph   = 1'b0;
      st_next.tick = 1'b0;
    end else begin
      cnt_next = (restart || wrap) ? '0 : cnt_reg + ONE;
      // Shadow is promoted only at a period boundary, using the value held before this edge.
      if ((restart || wrap) && st_reg.pend) begin
        d_next       = s_reg;
        st_next.pend = 1'b0;
      end
      st_next.run  = 1'b1;
      half         = ({1'b0, d_next} + ONE_X) >> 1;
      st_next.ph   = ({1'b0, cnt_next} < half);
      st_next.tick = (cnt_next == '0);
    end

    if (wr) begin
      s_next       = (wr_data < MIN_D) ? MIN_D : wr_data;
      st_next.pend = 1'b1;
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      d_reg   <= DEF_D;
      s_reg   <= DEF_D;
      cnt_reg <= '0;
      st_reg  <= '0;
    end else begin
      d_reg   <= d_next;
      s_reg   <= s_next;
      cnt_reg <= cnt_next;
      st_reg  <= st_next;
    end
  end

  assign clko = st_reg.ph;
  assign tick = st_reg.tick;
  assign pend = st_reg.pend;

endmodule

// File: rtl/clk_div_multi.sv
// N_CH independent glitch-free clock dividers sharing one divisor write port.
// Define CLKDIV_SYNC_EN to add the sync input that phase-aligns all enabled channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int W       = 31,
  parameter int DEF_DIV = 50000000
) (
  input  logic            clki,
  input  logic            rst_n,
  input  logic [N_CH-1:0] en,
  input  logic            div_wr,
  input  logic [3:0]      div_sel,
  input  logic [W-1:0]    div_data,
`ifdef CLKDIV_SYNC_EN
  input  logic            sync,
`endif
  output logic [N_CH-1:0] clko,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] pend
);

  // Selects at or above N_CH match no channel, so such writes fall away.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic wr_ch;
      assign wr_ch = div_wr && (div_sel == 4'(gi));

      clk_div_ch #(
        .W       (W),
        .DEF_DIV (DEF_DIV)
      ) u_ch (
        .clki    (clki),
        .rst_n   (rst_n),
        .en      (en[gi]),
        .wr      (wr_ch),
        .wr_data (div_data),
`ifdef CLKDIV_SYNC_EN
        .sync    (sync),
`endif
        .clko    (clko[gi]),
        .tick    (tick[gi]),
        .pend    (pend[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (N_CH=2, W=8, DEF_DIV=4); sync section needs CLKDIV_SYNC_EN.
module tb_clk_div_multi;

  localparam int N_CH    = 2;
  localparam int W       = 8;
  localparam int DEF_DIV = 4;

  logic            clki;
  logic            rst_n;
  logic [N_CH-1:0] en;
  logic            div_wr;
  logic [3:0]      div_sel;
  logic [W-1:0]    div_data;
`ifdef CLKDIV_SYNC_EN
  logic            sync;
`endif
  logic [N_CH-1:0] clko;
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] pend;

  int n_tests = 0;
  int n_fail  = 0;
  int hi, tk;
  bit found;

  clk_div_multi #(
    .N_CH    (N_CH),
    .W       (W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clki     (clki),
    .rst_n    (rst_n),
    .en       (en),
    .div_wr   (div_wr),
    .div_sel  (div_sel),
    .div_data (div_data),
`ifdef CLKDIV_SYNC_EN
    .sync     (sync),
`endif
    .clko     (clko),
    .tick     (tick),
    .pend     (pend)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clki);
    #1;
  endtask

  // Bit (n-1-i) of each pattern is the expected value after the i-th edge.
  task automatic run(input string tag, input int n,
                     input logic [15:0] c0, input logic [15:0] t0,
                     input logic [15:0] c1, input logic [15:0] t1);
    int b;
    for (int i = 0; i < n; i++) begin
      step();
      b = n - 1 - i;
      check($sformatf("%s clko[%0d]", tag, i), {30'd0, clko}, {30'd0, c1[b], c0[b]});
      check($sformatf("%s tick[%0d]", tag, i), {30'd0, tick}, {30'd0, t1[b], t0[b]});
    end
  endtask

  task automatic wr_set(input logic [3:0] sel, input logic [W-1:0] data);
    div_wr   = 1'b1;
    div_sel  = sel;
    div_data = data;
  endtask

  task automatic wr_clr();
    div_wr = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    en       = 2'b00;
    div_wr   = 1'b0;
    div_sel  = 4'd0;
    div_data = '0;
`ifdef CLKDIV_SYNC_EN
    sync     = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    check("reset clko", {30'd0, clko}, 32'd0);
    check("reset tick", {30'd0, tick}, 32'd0);
    check("reset pend", {30'd0, pend}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    en    = 2'b11;

    // Default divisor 4 on both channels
    run("r031", 8, 16'b11001100, 16'b10001000, 16'b11001100, 16'b10001000);
    run("pre32", 2, 16'b11, 16'b10, 16'b11, 16'b10);

    // D=5 to ch0 mid-period: waits for the wrap
    wr_set(4'd0, 8'd5);
    run("w32", 1, 16'b0, 16'b0, 16'b0, 16'b0);
    wr_clr();
    check("w32 pend", {30'd0, pend}, 32'b01);
    run("hold32", 1, 16'b0, 16'b0, 16'b0, 16'b0);
    check("hold32 pend", {30'd0, pend}, 32'b01);
    run("wrap32", 1, 16'b1, 16'b1, 16'b1, 16'b1);
    check("wrap32 pend", {30'd0, pend}, 32'b00);
    run("r032", 5, 16'b11001, 16'b00001, 16'b10011, 16'b00010);

    // D=0 to ch1 is stored as 2
    wr_set(4'd1, 8'd0);
    run("w33", 1, 16'b1, 16'b0, 16'b0, 16'b0);
    wr_clr();
    check("w33 pend", {30'd0, pend}, 32'b10);
    run("r033", 7, 16'b1001110, 16'b0001000, 16'b0101010, 16'b0101010);
    check("r033 pend", {30'd0, pend}, 32'b00);

    // Write on ch0's wrap edge, then overwrite before the next wrap
    run("pre34", 1, 16'b0, 16'b0, 16'b1, 16'b1);
    wr_set(4'd0, 8'd6);
    run("w34a", 1, 16'b1, 16'b1, 16'b0, 16'b0);
    wr_clr();
    check("w34a pend", {30'd0, pend}, 32'b01);
    run("mid34", 1, 16'b1, 16'b0, 16'b1, 16'b1);
    wr_set(4'd0, 8'd3);
    run("w34b", 1, 16'b1, 16'b0, 16'b0, 16'b0);
    wr_clr();
    check("w34b pend", {30'd0, pend}, 32'b01);
    run("r034", 9, 16'b001101101, 16'b001001001, 16'b101010101, 16'b101010101);
    check("r034 pend", {30'd0, pend}, 32'b00);

    // Disable ch0 for 3 cycles with a write landing while disabled
    run("pre35", 1, 16'b1, 16'b0, 16'b0, 16'b0);
    en = 2'b10;
    wr_set(4'd0, 8'd4);
    run("off35a", 1, 16'b0, 16'b0, 16'b1, 16'b1);
    wr_clr();
    check("off35a pend", {30'd0, pend}, 32'b01);
    run("off35b", 2, 16'b00, 16'b00, 16'b01, 16'b01);
    check("off35b pend", {30'd0, pend}, 32'b01);
    en = 2'b11;
    run("re35", 4, 16'b1100, 16'b1000, 16'b0101, 16'b0101);
    check("re35 pend", {30'd0, pend}, 32'b00);

    // Asynchronous reset mid-period discards a pending write
    wr_set(4'd1, 8'd7);
    run("pre_rst", 1, 16'b1, 16'b1, 16'b0, 16'b0);
    wr_clr();
    check("pre_rst pend", {30'd0, pend}, 32'b10);
    #2 rst_n = 1'b0;
    #1;
    check("async rst clko", {30'd0, clko}, 32'd0);
    check("async rst tick", {30'd0, tick}, 32'd0);
    check("async rst pend", {30'd0, pend}, 32'd0);
    step();
    check("held rst clko", {30'd0, clko}, 32'd0);
    rst_n = 1'b1;
    run("post_rst", 8, 16'b11001100, 16'b10001000, 16'b11001100, 16'b10001000);
    check("post_rst pend", {30'd0, pend}, 32'b00);

    // Select beyond N_CH is ignored
    wr_set(4'd2, 8'd9);
    run("sel2", 1, 16'b1, 16'b1, 16'b1, 16'b1);
    wr_clr();
    check("sel2 pend", {30'd0, pend}, 32'b00);
    run("r_sel2", 4, 16'b1001, 16'b0001, 16'b1001, 16'b0001);

    // Maximum divisor 255: 128 high cycles, period 255
    wr_set(4'd1, 8'd255);
    step();
    wr_clr();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (tick[1] === 1'b1) found = 1'b1;
    end
    check("max apply tick", {31'd0, found}, 32'd1);
    check("max apply pend", {31'd0, pend[1]}, 32'd0);
    check("max first high", {31'd0, clko[1]}, 32'd1);
    hi = 1;
    tk = 0;
    for (int i = 0; i < 254; i++) begin
      step();
      if (clko[1] === 1'b1) hi++;
      if (tick[1] === 1'b1) tk++;
    end
    check("max high count", hi, 32'd128);
    check("max early ticks", tk, 32'd0);
    step();
    check("max period end", {31'd0, tick[1]}, 32'd1);

`ifdef CLKDIV_SYNC_EN
    // D=4 and D=6 aligned by sync, realigning every 12 cycles
    wr_set(4'd1, 8'd6);
    step();
    wr_clr();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (tick[1] === 1'b1) found = 1'b1;
    end
    check("sync pre tick", {31'd0, found}, 32'd1);
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync tick", {30'd0, tick}, 32'b11);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("sync align[%0d]", k), {30'd0, tick},
            {30'd0, (k % 6 == 0), (k % 4 == 0)});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
